freq_step_ctrl: RTL and testbench

Upstream control stage for the sine-PWM generator. Turns three raw push-buttons (up, down, fast) into the 12-bit per-sample period count `Nsalida` and a load strobe `opr`, which drive the generator's `Nentrada`/`opr` inputs. Includes synchronisation, debounce, saturating step arithmetic and optional hold-to-repeat.

---
 rtl/freq_step_pkg.sv | 56 +++++
 rtl/btn_debounce.sv | 45 ++++
 rtl/freq_step_ctrl.sv | 164 ++++++++++++++++
 tb/tb_freq_step_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_step_pkg.sv
// Shared definitions for the push-button frequency step controller:
// N and arithmetic widths, default bounds, FSM and command encodings,
// and the saturating step helper.
package freq_step_pkg;

  localparam int N_W = 12;
  localparam int A_W = 13;

  localparam logic [N_W-1:0] N_MIN_DEF  = 12'd1;
  localparam logic [N_W-1:0] N_MAX_DEF  = 12'd4095;
  localparam logic [N_W-1:0] N_INIT_DEF = 12'd100;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STEP     = 3'd1,
    ST_HOLD     = 3'd2,
    ST_REPEAT   = 3'd3,
    ST_WAIT_REL = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DN   = 2'd2
  } cmd_t;

  // One saturating step at 13 bits; a borrow out of bit 12 means the
  // subtraction went negative and is clamped to the lower bound.
  function automatic logic [N_W-1:0] step_apply(
    input logic [N_W-1:0] n,
    input logic [N_W-1:0] step,
    input cmd_t           cmd,
    input logic [N_W-1:0] n_min,
    input logic [N_W-1:0] n_max
  );
    logic [A_W-1:0] acc;
    logic [N_W-1:0] res;
    acc = {A_W{1'b0}};
    res = n;
    case (cmd)
      CMD_UP: begin
        acc = {1'b0, n} + {1'b0, step};
        if (acc > {1'b0, n_max}) res = n_max;
        else                     res = acc[N_W-1:0];
      end
      CMD_DN: begin
        acc = {1'b0, n} - {1'b0, step};
        if (acc[A_W-1] || (acc < {1'b0, n_min})) res = n_min;
        else                                     res = acc[N_W-1:0];
      end
      default: res = n;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter: the output level
// follows the synchronised input only after DEB_CYCLES consecutive cycles
// of disagreement.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             sync1_r;
  logic             sync2_r;
  logic             dout_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise the raw level and accept it once it has been stable long enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      dout_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      if (sync2_r != dout_r) begin
        if (cnt_r == CNT_W'(DEB_CYCLES - 1)) begin
          dout_r <= sync2_r;
          cnt_r  <= {CNT_W{1'b0}};
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/freq_step_ctrl.sv
// Push-button control of the sine-PWM period count Nsalida with a one-cycle
// load strobe opr. Buttons are synchronised and debounced, then an FSM
// applies saturating steps.
// Build option FREQ_STEP_AUTOREPEAT_EN: when defined, a held button
// auto-repeats (HOLD/REPEAT); otherwise each press gives exactly one step.
module freq_step_ctrl
  import freq_step_pkg::*;
#(
  parameter int             DEB_CYCLES = 500000,
  parameter int             REP_DELAY  = 25000000,
  parameter int             REP_PERIOD = 5000000,
  parameter logic [N_W-1:0] N_INIT     = N_INIT_DEF,
  parameter logic [N_W-1:0] N_MIN      = N_MIN_DEF,
  parameter logic [N_W-1:0] N_MAX      = N_MAX_DEF,
  parameter logic [N_W-1:0] STEP_SMALL = 12'd1,
  parameter logic [N_W-1:0] STEP_LARGE = 12'd64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_up,
  input  logic           btn_dn,
  input  logic           btn_fast,
  output logic [N_W-1:0] Nsalida,
  output logic           opr
);

  logic up_deb;
  logic dn_deb;
  logic fast_deb;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst(rst), .din(btn_up), .dout(up_deb)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk(clk), .rst(rst), .din(btn_dn), .dout(dn_deb)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fast (
    .clk(clk), .rst(rst), .din(btn_fast), .dout(fast_deb)
  );

  cmd_t           cmd_s;
  cmd_t           cmd_lat_r;
  state_t         state_r;
  state_t         state_nx;
  logic           step_en_s;
  logic [N_W-1:0] n_r;
  logic [N_W-1:0] n_nx_s;
  logic           init_r;
  logic           pend_r;
  logic           opr_r;

`ifdef FREQ_STEP_AUTOREPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  logic [REP_W-1:0] rep_cnt_r;
  logic [REP_W-1:0] rep_cnt_nx;
`endif

  // Decode the debounced buttons; pressing both at once is treated as no command.
  always_comb begin
    cmd_s = CMD_NONE;
    if (up_deb && !dn_deb) begin
      cmd_s = CMD_UP;
    end else if (dn_deb && !up_deb) begin
      cmd_s = CMD_DN;
    end else begin
      cmd_s = CMD_NONE;
    end
  end

  // Next-state logic and the step-enable for the step FSM.
  always_comb begin
    state_nx  = state_r;
    step_en_s = 1'b0;
`ifdef FREQ_STEP_AUTOREPEAT_EN
    rep_cnt_nx = rep_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (cmd_s != CMD_NONE) state_nx = ST_STEP;
        else                   state_nx = ST_IDLE;
      end
      ST_STEP: begin
        step_en_s = 1'b1;
`ifdef FREQ_STEP_AUTOREPEAT_EN
        state_nx   = ST_HOLD;
        rep_cnt_nx = {REP_W{1'b0}};
`else
        state_nx   = ST_WAIT_REL;
`endif
      end
`ifdef FREQ_STEP_AUTOREPEAT_EN
      // The latched command is never NONE, so a mismatch also covers release.
      ST_HOLD: begin
        if (cmd_s != cmd_lat_r) begin
          state_nx = ST_IDLE;
        end else if (rep_cnt_r == REP_W'(REP_DELAY - 1)) begin
          step_en_s  = 1'b1;
          state_nx   = ST_REPEAT;
          rep_cnt_nx = {REP_W{1'b0}};
        end else begin
          rep_cnt_nx = rep_cnt_r + REP_W'(1);
        end
      end
      ST_REPEAT: begin
        if (cmd_s != cmd_lat_r) begin
          state_nx = ST_IDLE;
        end else if (rep_cnt_r == REP_W'(REP_PERIOD - 1)) begin
          step_en_s  = 1'b1;
          rep_cnt_nx = {REP_W{1'b0}};
        end else begin
          rep_cnt_nx = rep_cnt_r + REP_W'(1);
        end
      end
`endif
      ST_WAIT_REL: begin
        if (cmd_s == CMD_NONE) state_nx = ST_IDLE;
        else                   state_nx = ST_WAIT_REL;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM state register; the direction is latched when a press is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cmd_lat_r <= CMD_NONE;
`ifdef FREQ_STEP_AUTOREPEAT_EN
      rep_cnt_r <= {REP_W{1'b0}};
`endif
    end else begin
      state_r <= state_nx;
      if ((state_r == ST_IDLE) && (cmd_s != CMD_NONE)) cmd_lat_r <= cmd_s;
`ifdef FREQ_STEP_AUTOREPEAT_EN
      rep_cnt_r <= rep_cnt_nx;
`endif
    end
  end

  // Candidate value; the step size is taken from the fast button as it is now.
  always_comb begin
    n_nx_s = step_apply(n_r, fast_deb ? STEP_LARGE : STEP_SMALL, cmd_lat_r, N_MIN, N_MAX);
  end

  // Update N and generate opr one cycle after a real change (or once after reset).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_r    <= N_INIT;
      init_r <= 1'b1;
      pend_r <= 1'b0;
      opr_r  <= 1'b0;
    end else begin
      init_r <= 1'b0;
      pend_r <= init_r | (step_en_s && (n_nx_s != n_r));
      opr_r  <= pend_r;
      if (step_en_s) n_r <= n_nx_s;
    end
  end

  assign Nsalida = n_r;
  assign opr     = opr_r;

endmodule

// File: tb/tb_freq_step_ctrl.sv
// Directed, scoreboard-checked bench for freq_step_ctrl. Each expected opr
// load value is queued when stimulus is driven and popped when opr fires.
module tb_freq_step_ctrl;

  logic        clk;
  logic        rst;
  logic        btn_up;
  logic        btn_dn;
  logic        btn_fast;
  logic [11:0] Nsalida;
  logic        opr;

  freq_step_ctrl #(
    .DEB_CYCLES(4),
    .REP_DELAY (20),
    .REP_PERIOD(8),
    .N_INIT    (12'd100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .btn_fast(btn_fast),
    .Nsalida (Nsalida),
    .opr     (opr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          passed = 0;
  int          total = 0;
  int          opr_cnt = 0;
  int          cyc_n = 0;
  int          chg_cyc = 0;
  int          snap = 0;
  bit          skip_lag = 1'b0;
  logic [11:0] prev_n;
  logic [11:0] model_n;
  logic [11:0] exp_q[$];

  function automatic logic [11:0] mstep(input logic [11:0] n, input bit up, input bit fast);
    int s;
    int r;
    s = fast ? 64 : 1;
    r = up ? (int'(n) + s) : (int'(n) - s);
    if (r > 4095) r = 4095;
    if (r < 1) r = 1;
    return r[11:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; sample after the edge and score any opr pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
    if (Nsalida !== prev_n) chg_cyc = cyc_n;
    if (opr === 1'b1) begin
      opr_cnt++;
      if (exp_q.size() == 0) begin
        chk("opr_unexpected", 32'(opr), 32'd0);
      end else begin
        chk("opr_n", 32'(Nsalida), 32'(exp_q.pop_front()));
        if (skip_lag) skip_lag = 1'b0;
        else chk("opr_lag", 32'(cyc_n - chg_cyc), 32'd1);
      end
    end
    prev_n = Nsalida;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.push_back(12'd100);
    skip_lag = 1'b1;
    model_n  = 12'd100;
    repeat (8) tick();
  endtask

  // One up/down press with the fast level chosen beforehand.
  task automatic press(input bit up, input bit fast);
    logic [11:0] nn;
    btn_fast = fast;
    repeat (8) tick();
    nn = mstep(model_n, up, fast);
    if (nn != model_n) begin
      exp_q.push_back(nn);
      model_n = nn;
    end
    if (up) btn_up = 1'b1;
    else    btn_dn = 1'b1;
    repeat (12) tick();
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    rst      = 1'b0;
    btn_up   = 1'b0;
    btn_dn   = 1'b0;
    btn_fast = 1'b0;
    prev_n   = 12'd100;
    model_n  = 12'd100;

    // Reset state and the release pulse in the second cycle.
    repeat (3) tick();
    chk("rst_n", 32'(Nsalida), 32'd100);
    chk("rst_opr", 32'(opr), 32'd0);
    exp_q.push_back(12'd100);
    skip_lag = 1'b1;
    opr_cnt  = 0;
    rst = 1'b1;
    tick();
    chk("rel_c1_opr", 32'(opr), 32'd0);
    tick();
    chk("rel_c2_opr", 32'(opr), 32'd1);
    repeat (10) tick();
    chk("rel_pulses", 32'(opr_cnt), 32'd1);

    // A 3-cycle glitch is one cycle short of the debounce window.
    btn_up = 1'b1;
    repeat (3) tick();
    btn_up = 1'b0;
    repeat (15) tick();
    chk("glitch_n", 32'(Nsalida), 32'd100);
    chk("glitch_pulses", 32'(opr_cnt), 32'd1);

    // A genuine 20-cycle press steps once.
    exp_q.push_back(12'd101);
    btn_up = 1'b1;
    repeat (20) tick();
    btn_up = 1'b0;
    repeat (15) tick();
    chk("up_n", 32'(Nsalida), 32'd101);
    chk("up_pulses", 32'(opr_cnt), 32'd2);

    // Fast down from 100: 36, then (with repeat) clamp to 1, then no change.
    do_reset();
    snap = opr_cnt;
    btn_fast = 1'b1;
    repeat (8) tick();
    exp_q.push_back(12'd36);
`ifdef FREQ_STEP_AUTOREPEAT_EN
    exp_q.push_back(12'd1);
`endif
    btn_dn = 1'b1;
    repeat (60) tick();
`ifdef FREQ_STEP_AUTOREPEAT_EN
    chk("dn_fast_n", 32'(Nsalida), 32'd1);
    chk("dn_fast_pulses", 32'(opr_cnt - snap), 32'd2);
    model_n = 12'd1;
`else
    chk("dn_fast_n", 32'(Nsalida), 32'd36);
    chk("dn_fast_pulses", 32'(opr_cnt - snap), 32'd1);
    model_n = 12'd36;
`endif
    btn_dn = 1'b0;
    repeat (15) tick();

    // Both buttons: no command; releasing dn leaves a clean UP press.
    btn_fast = 1'b0;
    repeat (8) tick();
    snap = opr_cnt;
    btn_up = 1'b1;
    btn_dn = 1'b1;
    repeat (20) tick();
    chk("both_n", 32'(Nsalida), 32'(model_n));
    chk("both_pulses", 32'(opr_cnt - snap), 32'd0);
    model_n = mstep(model_n, 1'b1, 1'b0);
    exp_q.push_back(model_n);
    btn_dn = 1'b0;
    repeat (16) tick();
    btn_up = 1'b0;
    repeat (12) tick();
    chk("dn_rel_n", 32'(Nsalida), 32'(model_n));
    chk("dn_rel_pulses", 32'(opr_cnt - snap), 32'd1);

    // Climb to 4090, then saturate at N_MAX.
    do_reset();
    for (int i = 0; i < 62; i++) press(1'b1, 1'b1);
    for (int i = 0; i < 22; i++) press(1'b1, 1'b0);
    chk("n_4090", 32'(Nsalida), 32'd4090);
    press(1'b1, 1'b1);
    chk("n_4095", 32'(Nsalida), 32'd4095);
    snap = opr_cnt;
    press(1'b1, 1'b1);
    chk("sat_n", 32'(Nsalida), 32'd4095);
    chk("sat_no_opr", 32'(opr_cnt - snap), 32'd0);

    // Long hold: a single step without auto-repeat; reset aborts mid-hold.
    do_reset();
    btn_fast = 1'b0;
    snap = opr_cnt;
    exp_q.push_back(12'd101);
    btn_up = 1'b1;
`ifdef FREQ_STEP_AUTOREPEAT_EN
    repeat (16) tick();
`else
    repeat (100) tick();
`endif
    chk("hold_n", 32'(Nsalida), 32'd101);
    chk("hold_pulses", 32'(opr_cnt - snap), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_n", 32'(Nsalida), 32'd100);
    chk("midrst_opr", 32'(opr), 32'd0);
    snap = opr_cnt;
    repeat (3) tick();
    chk("midrst_pulses", 32'(opr_cnt - snap), 32'd0);
    btn_up = 1'b0;
    rst = 1'b1;
    exp_q.push_back(12'd100);
    skip_lag = 1'b1;
    repeat (10) tick();
    chk("midrst_rel_n", 32'(Nsalida), 32'd100);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
